// File: rtl/usb_stream_arb_if.sv
// Byte-stream bundle between the capture FIFOs, the packetizing arbiter and the FT2232 streamer.
// The arbiter takes the master side; the FIFOs and the streamer together drive the slave side.
interface usb_stream_arb_if #(
  parameter int NCH     = 4,
  parameter int LEVEL_W = 8
);
  logic [8*NCH-1:0]       ch_data;
  logic [NCH-1:0]         ch_empty;
  logic [LEVEL_W*NCH-1:0] ch_level;
  logic [NCH-1:0]         ch_rd;
  logic                   have_space;
  logic [7:0]             data;
  logic                   wr;

  modport master (
    input  ch_data, ch_empty, ch_level, have_space,
    output ch_rd, data, wr
  );

  modport slave (
    output ch_data, ch_empty, ch_level, have_space,
    input  ch_rd, data, wr
  );
endinterface

// File: rtl/usb_stream_arb.sv
// Round-robin packetizing arbiter: frames one FWFT channel at a time as header (0xA0|ch), length, payload
// onto the shared USB byte stream.
module usb_stream_arb #(
  parameter int NCH       = 4,
  parameter int LEVEL_W   = 8,
  parameter int MAX_BURST = 64
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             enable,
  usb_stream_arb_if.master bus,
  output logic             busy,
  output logic [NCH-1:0]   grant,
  output logic [15:0]      pkt_count
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMP_W = (LEVEL_W > 8) ? LEVEL_W : 8;

  typedef enum logic [1:0] {IDLE, HDR, LEN, DATA} state_t;

  state_t            state, state_nx;
  logic [CH_W-1:0]   g, g_nx, last, last_nx;
  logic [7:0]        len, len_nx, remaining, remaining_nx;
  logic [7:0]        data_nx;
  logic              wr_nx;
  logic [15:0]       pkt_nx;
  logic [NCH-1:0]    elig, rd;
  logic              found;
  logic [CH_W-1:0]   pick, cand;
  logic [LEVEL_W-1:0] pick_level;
  logic [CMP_W-1:0]  pick_level_ext;
  logic [7:0]        pick_len;

  always_comb begin
    for (int i = 0; i < NCH; i++)
      elig[i] = !bus.ch_empty[i] && (bus.ch_level[LEVEL_W*i +: LEVEL_W] != '0);
  end

  // Search starts just after the last served channel so every channel gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CH_W'((int'(last) + k) % NCH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Clamp at full level width before narrowing, so a large level never aliases to a small length.
  assign pick_level     = bus.ch_level[LEVEL_W*pick +: LEVEL_W];
  assign pick_level_ext = CMP_W'(pick_level);
  assign pick_len       = (pick_level_ext > CMP_W'(MAX_BURST)) ? 8'(MAX_BURST) : 8'(pick_level_ext);

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    g_nx         = g;
    last_nx      = last;
    len_nx       = len;
    remaining_nx = remaining;
    data_nx      = bus.data;
    wr_nx        = 1'b0;
    pkt_nx       = pkt_count;
    rd           = '0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          g_nx     = pick;
          len_nx   = pick_len;
          state_nx = HDR;
        end
      end
      HDR: begin
        if (bus.have_space) begin
          data_nx  = 8'hA0 | 8'(g);
          wr_nx    = 1'b1;
          state_nx = LEN;
        end
      end
      LEN: begin
        if (bus.have_space) begin
          data_nx      = len;
          wr_nx        = 1'b1;
          remaining_nx = len;
          state_nx     = DATA;
        end
      end
      DATA: begin
        // An empty channel mid-packet just stalls; the pop and the write stay paired.
        if (bus.have_space && !bus.ch_empty[g]) begin
          rd[g]        = 1'b1;
          data_nx      = bus.ch_data[8*g +: 8];
          wr_nx        = 1'b1;
          remaining_nx = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_nx = IDLE;
            last_nx  = g;
            pkt_nx   = pkt_count + 16'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      g         <= '0;
      last      <= CH_W'(NCH - 1);
      len       <= '0;
      remaining <= '0;
      bus.data  <= 8'h00;
      bus.wr    <= 1'b0;
      pkt_count <= '0;
    end else begin
      state     <= state_nx;
      g         <= g_nx;
      last      <= last_nx;
      len       <= len_nx;
      remaining <= remaining_nx;
      bus.data  <= data_nx;
      bus.wr    <= wr_nx;
      pkt_count <= pkt_nx;
    end
  end

  assign bus.ch_rd = rd;
  assign busy      = (state != IDLE);
  assign grant     = busy ? (NCH'(1) << g) : '0;
endmodule

// File: tb/tb_usb_stream_arb.sv
// Directed bench for usb_stream_arb: queue-backed FWFT channel models feed the arbiter and a
// negedge monitor records every byte written to the streamer.
module tb_usb_stream_arb;
  localparam int NCH       = 4;
  localparam int LEVEL_W   = 8;
  localparam int MAX_BURST = 64;

  logic           mclk   = 1'b0;
  logic           reset  = 1'b0;
  logic           enable = 1'b0;
  logic           busy;
  logic [NCH-1:0] grant;
  logic [15:0]    pkt_count;

  int checks   = 0;
  int failures = 0;

  usb_stream_arb_if #(.NCH(NCH), .LEVEL_W(LEVEL_W)) bus ();

  usb_stream_arb #(.NCH(NCH), .LEVEL_W(LEVEL_W), .MAX_BURST(MAX_BURST)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .grant     (grant),
    .pkt_count (pkt_count)
  );

  always #5 mclk = ~mclk;

  // Channel FIFO models: pop on the edge that sees ch_rd, present the new head 1 ns later.
  logic [7:0]     fifo [NCH][$];
  logic [NCH-1:0] force_empty = '0;
  int             cyc = 0;

  always @(posedge mclk) begin
    cyc++;
    for (int i = 0; i < NCH; i++)
      if (bus.ch_rd[i] === 1'b1 && fifo[i].size() > 0) void'(fifo[i].pop_front());
    #1;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_data[8*i +: 8]              = (fifo[i].size() > 0) ? fifo[i][0] : 8'h00;
      bus.ch_empty[i]                    = force_empty[i] || (fifo[i].size() == 0);
      bus.ch_level[LEVEL_W*i +: LEVEL_W] = LEVEL_W'(fifo[i].size());
    end
  end

  logic [7:0] out_q [$];
  int         out_cyc [$];
  int         rd_cnt [NCH];
  int         wr_low   = 0;
  int         rd_low   = 0;
  int         multi_rd = 0;

  always @(negedge mclk) begin
    if (bus.wr === 1'b1) begin
      out_q.push_back(bus.data);
      out_cyc.push_back(cyc);
    end
    for (int i = 0; i < NCH; i++)
      if (bus.ch_rd[i] === 1'b1) rd_cnt[i]++;
    if (bus.have_space === 1'b0 && bus.wr === 1'b1) wr_low++;
    if (bus.have_space === 1'b0 && bus.ch_rd !== '0) rd_low++;
    if ($countones(bus.ch_rd) > 1) multi_rd++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #2;
  endtask

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    for (int i = 0; i < NCH; i++) rd_cnt[i] = 0;
    wr_low = 0;
    rd_low = 0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    enable         = 1'b0;
    bus.have_space = 1'b1;
    force_empty    = '0;
    for (int i = 0; i < NCH; i++) fifo[i].delete();
    tick(3);
    reset = 1'b1;
    tick(1);
    clear_mon();
  endtask

  task automatic wait_pkts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pkt_count >= 16'(target)) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.have_space = 1'b1;
    fifo[0].push_back(8'h55);
    enable = 1'b1;
    tick(4);
    checks++; if (bus.wr !== 1'b0)      begin failures++; $display("FAIL reset_wr got=%b exp=0", bus.wr); end
    checks++; if (bus.data !== 8'h00)   begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data); end
    checks++; if (grant !== 4'b0000)    begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pkt_count !== 16'h0)  begin failures++; $display("FAIL reset_pkt_count got=%h exp=0000", pkt_count); end
    checks++; if (bus.ch_rd !== 4'b0)   begin failures++; $display("FAIL reset_ch_rd got=%b exp=0000", bus.ch_rd); end
    enable = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] exp [$] = '{8'hA1, 8'h03, 8'h11, 8'h22, 8'h33};
    int bad_gap = 0;
    do_reset();
    fifo[1].push_back(8'h11); fifo[1].push_back(8'h22); fifo[1].push_back(8'h33);
    tick(1);
    enable = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (grant !== 4'b0010)   begin failures++; $display("FAIL single_grant got=%b exp=0010", grant); end
    wait_pkts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout pkt_count=%0d exp=1", pkt_count); end
    checks++; if (out_q.size() != exp.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", out_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        failures++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 8'h00, exp[i]);
      end
    end
    for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 1) bad_gap++;
    checks++; if (bad_gap != 0)        begin failures++; $display("FAIL single_consecutive gaps=%0d exp=0", bad_gap); end
    checks++; if (rd_cnt[1] != 3 || rd_cnt[0] != 0 || rd_cnt[2] != 0 || rd_cnt[3] != 0)
      begin failures++; $display("FAIL single_rd got=%0d/%0d/%0d/%0d exp=0/3/0/0", rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3]); end
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL single_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (busy !== 1'b0 || grant !== 4'b0) begin failures++; $display("FAIL single_idle busy=%b grant=%b exp=0/0000", busy, grant); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp [$] = '{8'hA0, 8'h02, 8'h01, 8'h02, 8'hA2, 8'h02, 8'h21, 8'h22, 8'hA3, 8'h02, 8'h31, 8'h32,
                            8'hA0, 8'h02, 8'h03, 8'h04, 8'hA2, 8'h02, 8'h23, 8'h24, 8'hA3, 8'h02, 8'h33, 8'h34};
    do_reset();
    fifo[0].push_back(8'h01); fifo[0].push_back(8'h02);
    fifo[2].push_back(8'h21); fifo[2].push_back(8'h22);
    fifo[3].push_back(8'h31); fifo[3].push_back(8'h32);
    tick(1);
    enable = 1'b1;
    wait_pkts(3, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout1 pkt_count=%0d exp=3", pkt_count); end
    fifo[0].push_back(8'h03); fifo[0].push_back(8'h04);
    fifo[2].push_back(8'h23); fifo[2].push_back(8'h24);
    fifo[3].push_back(8'h33); fifo[3].push_back(8'h34);
    wait_pkts(6, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout2 pkt_count=%0d exp=6", pkt_count); end
    checks++; if (out_q.size() != exp.size()) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", out_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        failures++; $display("FAIL rr_byte[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 8'h00, exp[i]);
      end
    end
    if (out_cyc.size() >= 9) begin
      checks++; if (out_cyc[4] - out_cyc[3] != 2) begin failures++; $display("FAIL rr_gap01 got=%0d exp=2", out_cyc[4] - out_cyc[3]); end
      checks++; if (out_cyc[8] - out_cyc[7] != 2) begin failures++; $display("FAIL rr_gap12 got=%0d exp=2", out_cyc[8] - out_cyc[7]); end
    end
  endtask

  task automatic test_burst_cap();
    bit ok;
    logic [7:0] exp [$];
    do_reset();
    for (int i = 0; i < 150; i++) fifo[0].push_back(8'(i));
    fifo[1].push_back(8'hB1); fifo[1].push_back(8'hB2); fifo[1].push_back(8'hB3);
    exp.push_back(8'hA0); exp.push_back(8'h40);
    for (int i = 0; i < 64; i++) exp.push_back(8'(i));
    exp.push_back(8'hA1); exp.push_back(8'h03);
    exp.push_back(8'hB1); exp.push_back(8'hB2); exp.push_back(8'hB3);
    exp.push_back(8'hA0); exp.push_back(8'h40);
    for (int i = 64; i < 128; i++) exp.push_back(8'(i));
    exp.push_back(8'hA0); exp.push_back(8'h16);
    for (int i = 128; i < 150; i++) exp.push_back(8'(i));
    tick(1);
    enable = 1'b1;
    wait_pkts(4, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_timeout pkt_count=%0d exp=4", pkt_count); end
    checks++; if (out_q.size() != exp.size()) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", out_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        failures++; $display("FAIL burst_byte[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 8'h00, exp[i]);
      end
    end
    checks++; if (rd_cnt[0] != 150) begin failures++; $display("FAIL burst_rd0 got=%0d exp=150", rd_cnt[0]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] exp [$] = '{8'hA2, 8'h08, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    do_reset();
    for (int i = 0; i < 8; i++) fifo[2].push_back(8'h50 + 8'(i));
    tick(1);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_q.size() >= 5) begin ok = 1'b1; break; end
      tick(1);
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_start_timeout bytes=%0d exp=5", out_q.size()); end
    wr_low = 0;
    rd_low = 0;
    bus.have_space = 1'b0;
    tick(5);
    bus.have_space = 1'b1;
    wait_pkts(1, 50, ok);
    checks++; if (!ok)        begin failures++; $display("FAIL bp_timeout pkt_count=%0d exp=1", pkt_count); end
    checks++; if (wr_low > 1) begin failures++; $display("FAIL bp_wr_while_low got=%0d exp<=1", wr_low); end
    checks++; if (rd_low != 0) begin failures++; $display("FAIL bp_rd_while_low got=%0d exp=0", rd_low); end
    checks++; if (out_q.size() != exp.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", out_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        failures++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 8'h00, exp[i]);
      end
    end
    if (out_cyc.size() == exp.size()) begin
      checks++;
      if (out_cyc[exp.size()-1] - out_cyc[0] != 14) begin
        failures++; $display("FAIL bp_span got=%0d exp=14", out_cyc[exp.size()-1] - out_cyc[0]);
      end
    end
    checks++; if (rd_cnt[2] != 8) begin failures++; $display("FAIL bp_rd2 got=%0d exp=8", rd_cnt[2]); end
  endtask

  task automatic test_enable_stall();
    bit ok;
    logic [7:0] exp [$] = '{8'hA0, 8'h04, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hA1, 8'h02, 8'hD1, 8'hD2};
    do_reset();
    for (int i = 1; i <= 4; i++) fifo[0].push_back(8'hC0 + 8'(i));
    fifo[1].push_back(8'hD1); fifo[1].push_back(8'hD2);
    tick(1);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      if (bus.wr === 1'b1 && bus.data === 8'hA0) begin ok = 1'b1; break; end
    end
    enable = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL en_hdr_timeout wr=%b data=%h exp=1/a0", bus.wr, bus.data); end
    wait_pkts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en_timeout1 pkt_count=%0d exp=1", pkt_count); end
    tick(10);
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL en_busy_low got=%b exp=0", busy); end
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL en_hold_pkt got=%0d exp=1", pkt_count); end
    checks++; if (out_q.size() != 6)   begin failures++; $display("FAIL en_hold_bytes got=%0d exp=6", out_q.size()); end
    checks++; if (rd_cnt[1] != 0)      begin failures++; $display("FAIL en_hold_rd1 got=%0d exp=0", rd_cnt[1]); end
    enable = 1'b1;
    wait_pkts(2, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en_timeout2 pkt_count=%0d exp=2", pkt_count); end
    checks++; if (out_q.size() != exp.size()) begin failures++; $display("FAIL en_count got=%0d exp=%0d", out_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        failures++; $display("FAIL en_byte[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_empty_stall();
    bit ok;
    int n = 0;
    int stall_err = 0;
    logic [7:0] exp [$] = '{8'hA3, 8'h04, 8'h61, 8'h62, 8'h63, 8'h64};
    do_reset();
    for (int i = 1; i <= 4; i++) fifo[3].push_back(8'h60 + 8'(i));
    tick(1);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      if (bus.wr === 1'b1) n++;
      if (n == 3) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL stall_start_timeout bytes=%0d exp=3", n); end
    force_empty[3] = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    repeat (5) begin
      if (bus.wr !== 1'b0 || bus.ch_rd !== 4'b0) stall_err++;
      @(negedge mclk);
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_quiet got=%0d active cycles exp=0", stall_err); end
    checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
    force_empty[3] = 1'b0;
    wait_pkts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout pkt_count=%0d exp=1", pkt_count); end
    checks++; if (out_q.size() != exp.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", out_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        failures++; $display("FAIL stall_byte[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 8'h00, exp[i]);
      end
    end
    checks++; if (rd_cnt[3] != 4) begin failures++; $display("FAIL stall_rd3 got=%0d exp=4", rd_cnt[3]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    fifo[1].push_back(8'hE1); fifo[1].push_back(8'hE2);
    for (int i = 1; i <= 6; i++) fifo[2].push_back(8'hF0 + 8'(i));
    tick(1);
    enable = 1'b1;
    wait_pkts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_first_timeout pkt_count=%0d exp=1", pkt_count); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      if (bus.wr === 1'b1 && bus.data === 8'hF2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_data_timeout wr=%b data=%h exp=1/f2", bus.wr, bus.data); end
    reset = 1'b0;
    #1;
    checks++; if (bus.wr !== 1'b0)     begin failures++; $display("FAIL rst_mid_wr got=%b exp=0", bus.wr); end
    checks++; if (bus.data !== 8'h00)  begin failures++; $display("FAIL rst_mid_data got=%h exp=00", bus.data); end
    checks++; if (grant !== 4'b0)      begin failures++; $display("FAIL rst_mid_grant got=%b exp=0000", grant); end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL rst_mid_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    fifo[1].push_back(8'hE3);
    fifo[3].push_back(8'h71);
    tick(2);
    clear_mon();
    reset = 1'b1;
    wait_pkts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_after_timeout pkt_count=%0d exp=1", pkt_count); end
    checks++;
    if (out_q.size() < 3 || out_q[0] !== 8'hA1 || out_q[1] !== 8'h01 || out_q[2] !== 8'hE3) begin
      failures++;
      $display("FAIL rst_after_first_pkt got=%h %h %h exp=a1 01 e3", (out_q.size() > 0) ? out_q[0] : 8'h00,
               (out_q.size() > 1) ? out_q[1] : 8'h00, (out_q.size() > 2) ? out_q[2] : 8'h00);
    end
  endtask

  task automatic test_rd_onehot();
    checks++; if (multi_rd != 0) begin failures++; $display("FAIL rd_onehot multi-bit cycles=%0d exp=0", multi_rd); end
  endtask

  initial begin
    bus.have_space = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_enable_stall();
    test_empty_stall();
    test_reset_mid();
    test_rd_onehot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
